// File: rtl/agc_seq_pkg.sv
// Shared types and default cycle counts for the instruction sequencer.
package agc_seq_pkg;

    typedef enum logic [2:0] {
        OP_SINGLE = 3'd0,
        OP_EXTEND = 3'd1,
        OP_INDEX  = 3'd2,
        OP_MP     = 3'd3,
        OP_DV     = 3'd4,
        OP_HALT   = 3'd5
    } op_class_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MULTI  = 2'd1,
        HALTED = 2'd2
    } seq_state_t;

    localparam int unsigned MP_CYCLES_DEF = 3;
    localparam int unsigned DV_CYCLES_DEF = 6;

    // Terminal count for an op that takes n execute cycles (counter runs 1..n-1).
    function automatic logic [2:0] cycles_to_limit(input int unsigned n);
        return 3'(n - 1);
    endfunction

endpackage

// File: rtl/instr_sequencer_multicycle_counter.sv
// Loadable 3-bit up-counter for multi-cycle execute phases.
// start loads cnt=1 and latches the terminal count; the counter then steps
// once per cycle until cnt reaches the terminal count, where done is raised
// and cnt holds until clear. cnt==0 means idle.
module multicycle_counter (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       clear,
    input  logic [2:0] limit,
    output logic [2:0] cnt,
    output logic       done
);

    logic [2:0] limit_q;

    assign done = (cnt != 3'd0) && (cnt == limit_q);

    // Clear beats start so a redirect always wins over a new multi-cycle op.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt     <= 3'd0;
            limit_q <= 3'd0;
        end else if (clear) begin
            cnt <= 3'd0;
        end else if (start) begin
            cnt     <= 3'd1;
            limit_q <= limit;
        end else if ((cnt != 3'd0) && !done) begin
            cnt <= cnt + 3'd1;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Sequencing controller between fetch and the instruction decoder.
// Optional feature macro: SEQ_PERF_EN adds saturating stall/issue counters
// (ports stall_cnt, issue_cnt).
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  RUN    | accepting one instruction per cycle from the decoder
//  MULTI  | stretching an MP/DV op; fetch stalled, phase counts up
//  HALTED | stopped after HALT; stall forever, only reset leaves
module instr_sequencer
    import agc_seq_pkg::*;
#(
    parameter int unsigned MP_CYCLES = MP_CYCLES_DEF,
    parameter int unsigned DV_CYCLES = DV_CYCLES_DEF,
    parameter int unsigned IDX_W     = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  op_class_t        op_class,
    input  logic [IDX_W-1:0] idx_data,
    output logic             extend_q,
    output logic             index_q,
    output logic [IDX_W-1:0] index_val,
    output logic             stall,
    output logic             issue,
    output logic [2:0]       phase,
    output logic             halted,
    output logic             intr_ok
`ifdef SEQ_PERF_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      issue_cnt
`endif
);

    if (MP_CYCLES < 1 || MP_CYCLES > 8) begin : g_bad_mp
        $error("instr_sequencer: MP_CYCLES must be in 1..8");
    end
    if (DV_CYCLES < 1 || DV_CYCLES > 8) begin : g_bad_dv
        $error("instr_sequencer: DV_CYCLES must be in 1..8");
    end

    localparam logic [2:0] MP_LIM = cycles_to_limit(MP_CYCLES);
    localparam logic [2:0] DV_LIM = cycles_to_limit(DV_CYCLES);

    seq_state_t state, state_nxt;

    logic       flush_eff;
    logic       ext_set;
    logic       idx_set;
    logic       pfx_clr;
    logic       cnt_start;
    logic       cnt_clear;
    logic [2:0] cnt_limit;
    logic [2:0] lim_sel;
    logic [2:0] cnt;
    logic       cnt_done;

    // HALTED ignores flush entirely.
    assign flush_eff = flush && (state != HALTED);

    multicycle_counter u_cnt (
        .clock (clock),
        .reset (reset),
        .start (cnt_start),
        .clear (cnt_clear),
        .limit (cnt_limit),
        .cnt   (cnt),
        .done  (cnt_done)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-cycle control outputs.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        issue     = 1'b0;
        phase     = 3'd0;
        ext_set   = 1'b0;
        idx_set   = 1'b0;
        pfx_clr   = 1'b0;
        cnt_start = 1'b0;
        cnt_clear = 1'b0;
        cnt_limit = MP_LIM;
        lim_sel   = (op_class == OP_DV) ? DV_LIM : MP_LIM;

        case (state)
            RUN: begin
                if (flush_eff) begin
                    cnt_clear = 1'b1;
                end else if (in_valid) begin
                    case (op_class)
                        OP_EXTEND: ext_set = 1'b1;
                        OP_INDEX:  idx_set = 1'b1;
                        OP_MP, OP_DV: begin
                            if (lim_sel == 3'd0) begin
                                issue   = 1'b1;
                                pfx_clr = 1'b1;
                            end else begin
                                stall     = 1'b1;
                                cnt_start = 1'b1;
                                cnt_limit = lim_sel;
                                state_nxt = MULTI;
                            end
                        end
                        OP_HALT: begin
                            issue     = 1'b1;
                            pfx_clr   = 1'b1;
                            state_nxt = HALTED;
                        end
                        // Unassigned encodings complete as ordinary single-cycle ops.
                        default: begin
                            issue   = 1'b1;
                            pfx_clr = 1'b1;
                        end
                    endcase
                end
            end
            MULTI: begin
                phase = cnt;
                if (flush_eff) begin
                    cnt_clear = 1'b1;
                    state_nxt = RUN;
                end else if (cnt_done) begin
                    issue     = 1'b1;
                    pfx_clr   = 1'b1;
                    cnt_clear = 1'b1;
                    state_nxt = RUN;
                end else begin
                    stall = 1'b1;
                end
            end
            HALTED: begin
                stall = 1'b1;
            end
            default: begin
                cnt_clear = 1'b1;
                state_nxt = RUN;
            end
        endcase
    end

    // Prefix flops: flush clears them; index_val is only reloaded, never cleared by flush.
    always_ff @(posedge clock) begin
        if (reset) begin
            extend_q  <= 1'b0;
            index_q   <= 1'b0;
            index_val <= '0;
        end else if (flush_eff || pfx_clr) begin
            extend_q <= 1'b0;
            index_q  <= 1'b0;
        end else begin
            if (ext_set) begin
                extend_q <= 1'b1;
            end
            if (idx_set) begin
                index_q   <= 1'b1;
                index_val <= idx_data;
            end
        end
    end

    assign halted  = (state == HALTED);
    assign intr_ok = (state == RUN) && !extend_q && !index_q && !stall;

`ifdef SEQ_PERF_EN
    // Saturating performance counters; survive flush, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= 32'd0;
            issue_cnt <= 32'd0;
        end else begin
            if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (issue && (issue_cnt != 32'hFFFF_FFFF)) begin
                issue_cnt <= issue_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed, table-driven bench for instr_sequencer (default MP=3, DV=6).
module tb_instr_sequencer;
    import agc_seq_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    op_class_t   op_class;
    logic [14:0] idx_data;
    logic        extend_q, index_q, stall, issue, halted, intr_ok;
    logic [14:0] index_val;
    logic [2:0]  phase;
`ifdef SEQ_PERF_EN
    logic [31:0] stall_cnt, issue_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    instr_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .op_class  (op_class),
        .idx_data  (idx_data),
        .extend_q  (extend_q),
        .index_q   (index_q),
        .index_val (index_val),
        .stall     (stall),
        .issue     (issue),
        .phase     (phase),
        .halted    (halted),
        .intr_ok   (intr_ok)
`ifdef SEQ_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .issue_cnt (issue_cnt)
`endif
    );

    always #5 clock = ~clock;

    // {extend_q, index_q, index_val, stall, issue, phase, halted, intr_ok}
    typedef struct {
        logic        fl;
        logic        v;
        op_class_t   op;
        logic [14:0] d;
        logic [23:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic fl, input logic v, input op_class_t op,
                                input logic [14:0] d, input logic ext, input logic iq,
                                input logic [14:0] iv, input logic st, input logic is,
                                input logic [2:0] ph, input logic hl, input logic io);
        vec_t r;
        r.fl  = fl;
        r.v   = v;
        r.op  = op;
        r.d   = d;
        r.exp = {ext, iq, iv, st, is, ph, hl, io};
        return r;
    endfunction

    function automatic logic [23:0] outs();
        return {extend_q, index_q, index_val, stall, issue, phase, halted, intr_ok};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        op_class = OP_SINGLE;
        idx_data = '0;

        // fl v op d | ext iq ival stall issue phase halted intr
        tbl.push_back(mk(0,0,OP_SINGLE,0,        0,0,15'd0, 0,0,3'd0,0,1));
        tbl.push_back(mk(0,1,OP_EXTEND,0,        0,0,15'd0, 0,0,3'd0,0,1));
        tbl.push_back(mk(0,1,OP_INDEX,15'o17,    1,0,15'd0, 0,0,3'd0,0,0));
        tbl.push_back(mk(0,1,OP_SINGLE,0,        1,1,15'o17,0,1,3'd0,0,0));
        tbl.push_back(mk(0,0,OP_SINGLE,0,        0,0,15'o17,0,0,3'd0,0,1));
        tbl.push_back(mk(0,1,OP_INDEX,15'd5,     0,0,15'o17,0,0,3'd0,0,1));
        tbl.push_back(mk(0,1,OP_INDEX,15'd9,     0,1,15'd5, 0,0,3'd0,0,0));
        tbl.push_back(mk(0,0,OP_SINGLE,0,        0,1,15'd9, 0,0,3'd0,0,0));
        tbl.push_back(mk(0,1,OP_SINGLE,0,        0,1,15'd9, 0,1,3'd0,0,0));
        tbl.push_back(mk(0,0,OP_SINGLE,0,        0,0,15'd9, 0,0,3'd0,0,1));
        // DV, 6 cycles; decoder inputs ignored while in MULTI
        tbl.push_back(mk(0,1,OP_DV,0,            0,0,15'd9, 1,0,3'd0,0,0));
        tbl.push_back(mk(0,0,OP_SINGLE,0,        0,0,15'd9, 1,0,3'd1,0,0));
        tbl.push_back(mk(0,1,OP_SINGLE,0,        0,0,15'd9, 1,0,3'd2,0,0));
        tbl.push_back(mk(0,1,OP_HALT,0,          0,0,15'd9, 1,0,3'd3,0,0));
        tbl.push_back(mk(0,0,OP_SINGLE,0,        0,0,15'd9, 1,0,3'd4,0,0));
        tbl.push_back(mk(0,0,OP_SINGLE,0,        0,0,15'd9, 0,1,3'd5,0,0));
        tbl.push_back(mk(0,0,OP_SINGLE,0,        0,0,15'd9, 0,0,3'd0,0,1));
        // MP killed by flush at phase 1, then a single issues at once
        tbl.push_back(mk(0,1,OP_MP,0,            0,0,15'd9, 1,0,3'd0,0,0));
        tbl.push_back(mk(1,0,OP_SINGLE,0,        0,0,15'd9, 0,0,3'd1,0,0));
        tbl.push_back(mk(0,1,OP_SINGLE,0,        0,0,15'd9, 0,1,3'd0,0,1));
        // MP run to completion
        tbl.push_back(mk(0,1,OP_MP,0,            0,0,15'd9, 1,0,3'd0,0,0));
        tbl.push_back(mk(0,0,OP_SINGLE,0,        0,0,15'd9, 1,0,3'd1,0,0));
        tbl.push_back(mk(0,0,OP_SINGLE,0,        0,0,15'd9, 0,1,3'd2,0,0));
        tbl.push_back(mk(0,0,OP_SINGLE,0,        0,0,15'd9, 0,0,3'd0,0,1));
        // flush clears prefix; flush + in_valid drops the instruction
        tbl.push_back(mk(0,1,OP_EXTEND,0,        0,0,15'd9, 0,0,3'd0,0,1));
        tbl.push_back(mk(1,1,OP_SINGLE,0,        1,0,15'd9, 0,0,3'd0,0,0));
        tbl.push_back(mk(0,0,OP_SINGLE,0,        0,0,15'd9, 0,0,3'd0,0,1));
        tbl.push_back(mk(1,1,OP_EXTEND,0,        0,0,15'd9, 0,0,3'd0,0,1));
        tbl.push_back(mk(0,0,OP_SINGLE,0,        0,0,15'd9, 0,0,3'd0,0,1));
        // prefix held across MP, cleared at completion
        tbl.push_back(mk(0,1,OP_EXTEND,0,        0,0,15'd9, 0,0,3'd0,0,1));
        tbl.push_back(mk(0,1,OP_MP,0,            1,0,15'd9, 1,0,3'd0,0,0));
        tbl.push_back(mk(0,0,OP_SINGLE,0,        1,0,15'd9, 1,0,3'd1,0,0));
        tbl.push_back(mk(0,0,OP_SINGLE,0,        1,0,15'd9, 0,1,3'd2,0,0));
        tbl.push_back(mk(0,0,OP_SINGLE,0,        0,0,15'd9, 0,0,3'd0,0,1));
        // INDEX then flush: index_q drops, index_val held
        tbl.push_back(mk(0,1,OP_INDEX,15'd3,     0,0,15'd9, 0,0,3'd0,0,1));
        tbl.push_back(mk(1,0,OP_SINGLE,0,        0,1,15'd3, 0,0,3'd0,0,0));
        tbl.push_back(mk(0,0,OP_SINGLE,0,        0,0,15'd3, 0,0,3'd0,0,1));
        // HALT issues on its own cycle
        tbl.push_back(mk(0,1,OP_HALT,0,          0,0,15'd3, 0,1,3'd0,0,1));

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset", 32'(outs()), 32'h000001);

        reset = 1'b0;
        foreach (tbl[i]) begin
            if (i != 0) @(negedge clock);
            flush    = tbl[i].fl;
            in_valid = tbl[i].v;
            op_class = tbl[i].op;
            idx_data = tbl[i].d;
            #1;
            check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // HALTED persists through flush and in_valid
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            flush    = c[0];
            in_valid = 1'b1;
            op_class = (c % 3 == 0) ? OP_EXTEND : ((c % 3 == 1) ? OP_INDEX : OP_SINGLE);
            idx_data = 15'(c);
            #1;
            check($sformatf("halt%0d", c), 32'({halted, stall, issue, intr_ok, extend_q, index_q}),
                  32'(6'b110000));
        end

        // Reset leaves HALTED and clears index_val
        @(negedge clock);
        reset    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        op_class = OP_SINGLE;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("after_halt_reset", 32'(outs()), 32'h000001);

        // 3 singles + 1 MP
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            in_valid = 1'b1;
            op_class = (k == 3) ? OP_MP : OP_SINGLE;
            #1;
            check($sformatf("pf_issue%0d", k), 32'({stall, issue}), (k == 3) ? 32'b10 : 32'b01);
        end
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        check("pf_mp1", 32'({stall, issue, phase}), 32'b10_001);
        @(negedge clock);
        #1;
        check("pf_mp2", 32'({stall, issue, phase}), 32'b01_010);
        @(negedge clock);
        #1;
        check("pf_idle", 32'(outs()), 32'h000001);
`ifdef SEQ_PERF_EN
        check("issue_cnt", issue_cnt, 32'd4);
        check("stall_cnt", stall_cnt, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
